// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid_if
//  Purpose  : valid/ready handshake bundle (payload + control bits) used on
//             both sides of pipe_stage_skid.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_stage_skid_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 12
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   // Producer side drives the item, consumer side answers with ready.
   modport master (output valid, output data, output ctrl, input  ready);
   modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid
//  Purpose  : Parametrised pipeline stage register with valid/ready handshake,
//             hold, flush, optional 2-entry skid buffer (registered in_ready),
//             occupancy output and saturating stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid #(
   parameter int DATA_W  = 32,
   parameter int CTRL_W  = 12,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  wire               clk,
   input  wire               rst_n,
   input  wire               flush,
   input  wire               hold,
   input  wire               stat_clr,
   pipe_stage_skid_if.slave  up,
   pipe_stage_skid_if.master dn,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Entry state: M is the head (visible on dn), S is the skid slot.
   logic              r_m_v;
   logic              r_s_v;
   logic [DATA_W-1:0] r_m_data;
   logic [CTRL_W-1:0] r_m_ctrl;
   logic [DATA_W-1:0] r_s_data;
   logic [CTRL_W-1:0] r_s_ctrl;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_out_valid;
   logic              w_out_fire;
   logic              w_in_ready;
   logic              w_in_fire;
   logic              w_m_v_nxt;
   logic              w_s_v_nxt;
   logic              w_m_load;
   logic              w_m_from_s;
   logic              w_s_load;

   assign w_out_valid = r_m_v & ~hold;
   assign w_out_fire  = w_out_valid & dn.ready;
   assign w_in_fire   = up.valid & w_in_ready & ~flush;

   // With the skid slot, in_ready comes straight from a flop so that the
   // downstream ready never ripples back upstream in the same cycle.
   generate
      if (SKID_EN != 0) begin : g_skid_ready
         assign w_in_ready = ~r_s_v;
      end else begin : g_single_ready
         assign w_in_ready = ~r_m_v | (dn.ready & ~hold);
      end
   endgenerate

   // Next-state and load-enable decode for the M/S entries.
   always_comb begin
      w_m_v_nxt  = r_m_v;
      w_s_v_nxt  = r_s_v;
      w_m_load   = 1'b0;
      w_m_from_s = 1'b0;
      w_s_load   = 1'b0;
      if (flush) begin
         // A same-cycle out_fire is already delivered; everything else drops.
         w_m_v_nxt = 1'b0;
         w_s_v_nxt = 1'b0;
      end else if (r_s_v) begin
         if (w_out_fire) begin
            w_m_from_s = 1'b1;
            w_s_v_nxt  = 1'b0;
         end
      end else if (r_m_v) begin
         if (w_in_fire && w_out_fire) begin
            w_m_load = 1'b1;
         end else if (w_in_fire && (SKID_EN != 0)) begin
            w_s_load  = 1'b1;
            w_s_v_nxt = 1'b1;
         end else if (w_out_fire) begin
            w_m_v_nxt = 1'b0;
         end
      end else if (w_in_fire) begin
         w_m_load  = 1'b1;
         w_m_v_nxt = 1'b1;
      end
   end

   // Valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_v <= 1'b0;
         r_s_v <= 1'b0;
      end else begin
         r_m_v <= w_m_v_nxt;
         r_s_v <= w_s_v_nxt;
      end
   end

   // M payload loads only from the input or from S; otherwise it holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_data <= '0;
         r_m_ctrl <= '0;
      end else if (w_m_load) begin
         r_m_data <= up.data;
         r_m_ctrl <= up.ctrl;
      end else if (w_m_from_s) begin
         r_m_data <= r_s_data;
         r_m_ctrl <= r_s_ctrl;
      end
   end

   // S payload loads only when an item arrives while M is stuck.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_data <= '0;
         r_s_ctrl <= '0;
      end else if (w_s_load) begin
         r_s_data <= up.data;
         r_s_ctrl <= up.ctrl;
      end
   end

   // Saturating count of cycles where M holds an item that is not consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (stat_clr) begin
         r_stall_cnt <= '0;
      end else if (r_m_v && !w_out_fire && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign up.ready  = w_in_ready;
   assign dn.valid  = w_out_valid;
   assign dn.data   = r_m_data;
   assign dn.ctrl   = r_m_ctrl & {CTRL_W{w_out_valid}};
   assign occupancy = {1'b0, r_m_v} + {1'b0, r_s_v};
   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
